// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//
// Keyboard event queue for the Z80 bus. Every toggle of ps2_key[10] is one
// press or release event from hps_io. Each event is stored in a small FIFO, so
// the CPU can poll at its own pace without losing keys.
//
// Ports
//   clk_24       system clock, rising edge
//   reset        synchronous, active-high reset
//   ps2_key      [7:0] scancode, [8] extended, [9] pressed, [10] event toggle
//   cpu_cs       block select (decoded I/O page)
//   cpu_addr     register select
//                  0 status   {nonempty, overflow, 0, count[4:0]}
//                  1 head     scancode
//                  2 head     {6'b0, pressed, ext}
//                  3 command  (write only; reads 8'h00)
//   cpu_wr_n     write strobe, active low. It may be held low for many
//                clocks, but only one command executes per strobe.
//   cpu_din      command bits: [0] pop, [1] clear overflow, [2] flush
//   cpu_dout     read data, combinational from registers
//   irq_pending  high while the FIFO holds at least one entry
//
// Parameter
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries. Legal values are 2..4.
//
// Build option
//   KEYFIFO_REPEAT_FILTER_EN  When defined, typematic repeats are dropped.
//                             A press that equals the last stored, still-held
//                             press is discarded.

module ps2_key_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        cpu_cs,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        irq_pending
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    // Storage layout is ps2_key[9:0]: [9] pressed, [8] ext, [7:0] code.
    logic [9:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  tog_q;
    logic                  wr_q;

    logic       wr_act;
    logic       cmd_fire;
    logic       cmd_pop;
    logic       cmd_clr;
    logic       cmd_flush;
    logic       event_det;
    logic       repeat_hit;
    logic       push_req;
    logic       empty;
    logic       full;
    logic       do_pop;
    logic       do_push;
    logic       drop;
    logic [9:0] head;
    logic [4:0] count5;
    logic       unused_din;

    assign unused_din = ^cpu_din[7:3];

    // A command fires only on the first cycle of a strobe. wr_q is also
    // loaded while reset is asserted. A strobe that is still held across the
    // release of reset therefore cannot fire until it is released and
    // asserted again.
    assign wr_act    = cpu_cs & ~cpu_wr_n;
    assign cmd_fire  = wr_act & ~wr_q & (cpu_addr == 2'd3);
    assign cmd_pop   = cmd_fire & cpu_din[0];
    assign cmd_clr   = cmd_fire & cpu_din[1];
    assign cmd_flush = cmd_fire & cpu_din[2];

    assign event_det = ps2_key[10] != tog_q;
    assign push_req  = event_det & ~repeat_hit;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Flush beats everything. A pop of an empty FIFO does nothing, even when
    // a push lands on the same cycle. A pop frees a slot, so a push to a full
    // FIFO is still stored when a pop happens on the same cycle.
    assign do_pop  = cmd_pop & ~empty & ~cmd_flush;
    assign do_push = push_req & (~full | do_pop) & ~cmd_flush;
    assign drop    = push_req & full & ~do_pop & ~cmd_flush;

`ifdef KEYFIFO_REPEAT_FILTER_EN
    logic       lp_valid;
    logic [8:0] lp_key;

    // Compare {ext, code} against the press that is currently held.
    assign repeat_hit = event_det & ps2_key[9] & lp_valid
                        & (ps2_key[8:0] == lp_key);

    always_ff @(posedge clk_24) begin
        if (reset) begin
            lp_valid <= 1'b0;
            lp_key   <= '0;
        end else if (cmd_flush) begin
            lp_valid <= 1'b0;
        end else if (event_det && !repeat_hit) begin
            if (ps2_key[9]) begin
                if (do_push) begin
                    lp_valid <= 1'b1;
                    lp_key   <= ps2_key[8:0];
                end
            end else if (lp_valid && ps2_key[8:0] == lp_key) begin
                lp_valid <= 1'b0;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clk_24) begin
        if (reset) begin
            // Taking the current toggle level during reset means the first
            // cycle after reset does not see a false event.
            tog_q    <= ps2_key[10];
            wr_q     <= wr_act;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tog_q <= ps2_key[10];
            wr_q  <= wr_act;

            if (cmd_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= ps2_key[9:0];
                    wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                count <= count + CW'(do_push) - CW'(do_pop);
            end

            // A dropped push wins over a clear on the same cycle, so the
            // loss is never hidden.
            if (drop) begin
                overflow <= 1'b1;
            end else if (cmd_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head   = empty ? 10'd0 : mem[rd_ptr];
    assign count5 = 5'(count);

    always_comb begin
        cpu_dout = 8'h00;
        if (!reset) begin
            case (cpu_addr)
                2'd0:    cpu_dout = {~empty, overflow, 1'b0, count5};
                2'd1:    cpu_dout = head[7:0];
                2'd2:    cpu_dout = {6'b0, head[9], head[8]};
                default: cpu_dout = 8'h00;
            endcase
        end
    end

    assign irq_pending = ~empty;

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

    logic        clk_24;
    logic        reset;
    logic [10:0] ps2_key;
    logic        cpu_cs;
    logic [1:0]  cpu_addr;
    logic        cpu_wr_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        irq_pending;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_24      (clk_24),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .irq_pending (irq_pending)
    );

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;

    typedef struct {
        int         kind;    // 0 key event, 1 CPU write
        logic [9:0] key;     // {pressed, ext, code}
        logic [1:0] waddr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] st;
        logic [7:0] code;
        logic [7:0] flags;
        logic       irq;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check(name, cpu_dout, exp);
    endtask

    task automatic key_ev(input logic [9:0] k);
        @(negedge clk_24);
        ps2_key = {~ps2_key[10], k};
        @(negedge clk_24);
    endtask

    task automatic wr_cmd(input logic [1:0] a, input logic [7:0] d, input int hold);
        @(negedge clk_24);
        cpu_cs   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        cpu_wr_n = 1'b0;
        repeat (hold) @(negedge clk_24);
        cpu_wr_n = 1'b1;
        cpu_cs   = 1'b0;
    endtask

    // Drives a key event and a command together, so both reach the same edge.
    task automatic key_and_cmd(input logic [9:0] k, input logic [7:0] d);
        @(negedge clk_24);
        ps2_key  = {~ps2_key[10], k};
        cpu_cs   = 1'b1;
        cpu_addr = 2'd3;
        cpu_din  = d;
        cpu_wr_n = 1'b0;
        @(negedge clk_24);
        cpu_wr_n = 1'b1;
        cpu_cs   = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 10'h21C, 2'd0, 8'h00, 0, 8'h81, 8'h1C, 8'h02, 1'b1};
        tbl[1]  = '{0, 10'h01C, 2'd0, 8'h00, 0, 8'h82, 8'h1C, 8'h02, 1'b1};
        tbl[2]  = '{1, 10'h000, 2'd3, 8'h01, 4, 8'h81, 8'h1C, 8'h00, 1'b1};
        tbl[3]  = '{1, 10'h000, 2'd3, 8'h01, 1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1, 10'h000, 2'd3, 8'h01, 2, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{0, 10'h375, 2'd0, 8'h00, 0, 8'h81, 8'h75, 8'h03, 1'b1};
        tbl[6]  = '{1, 10'h000, 2'd1, 8'h01, 1, 8'h81, 8'h75, 8'h03, 1'b1};
        tbl[7]  = '{0, 10'h175, 2'd0, 8'h00, 0, 8'h82, 8'h75, 8'h03, 1'b1};
        tbl[8]  = '{1, 10'h000, 2'd3, 8'h01, 1, 8'h81, 8'h75, 8'h01, 1'b1};
        tbl[9]  = '{1, 10'h000, 2'd2, 8'h04, 1, 8'h81, 8'h75, 8'h01, 1'b1};
        tbl[10] = '{1, 10'h000, 2'd3, 8'h04, 1, 8'h00, 8'h00, 8'h00, 1'b0};

        reset    = 1'b1;
        ps2_key  = 11'h400;
        cpu_cs   = 1'b0;
        cpu_addr = 2'd0;
        cpu_wr_n = 1'b1;
        cpu_din  = 8'h00;
        repeat (3) @(negedge clk_24);
        reset = 1'b0;
        repeat (10) @(negedge clk_24);
        rd("reset status", 2'd0, 8'h00);
        check("reset irq", {7'b0, irq_pending}, 8'h00);
        rd("reset addr3", 2'd3, 8'h00);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].kind == 0) key_ev(tbl[i].key);
            else wr_cmd(tbl[i].waddr, tbl[i].wdata, tbl[i].hold);
            @(negedge clk_24);
            rd($sformatf("row%0d status", i), 2'd0, tbl[i].st);
            rd($sformatf("row%0d code", i), 2'd1, tbl[i].code);
            rd($sformatf("row%0d flags", i), 2'd2, tbl[i].flags);
            check($sformatf("row%0d irq", i), {7'b0, irq_pending}, {7'b0, tbl[i].irq});
        end

        // Fill past full: 17 presses, 0x10..0x20. The last one is dropped.
        for (int i = 0; i < 17; i++) key_ev(10'h200 | 10'(8'h10 + i));
        rd("full status", 2'd0, 8'hD0);
        rd("full head", 2'd1, 8'h10);
        rd("full flags", 2'd2, 8'h02);
        wr_cmd(2'd3, 8'h02, 1);
        @(negedge clk_24);
        rd("clr ovf status", 2'd0, 8'h90);

        // Full FIFO with a push and a pop on the same cycle.
        key_and_cmd(10'h240, 8'h01);
        rd("push+pop full status", 2'd0, 8'h90);
        rd("push+pop full head", 2'd1, 8'h11);
        for (int i = 0; i < 15; i++) wr_cmd(2'd3, 8'h01, 1);
        @(negedge clk_24);
        rd("tail entry code", 2'd1, 8'h40);
        rd("tail entry status", 2'd0, 8'h81);

        // Refill, then send a dropped push together with a clear: set wins.
        for (int i = 0; i < 15; i++) key_ev(10'h200 | 10'(8'h50 + i));
        rd("refill status", 2'd0, 8'h90);
        key_and_cmd(10'h260, 8'h02);
        rd("set beats clear", 2'd0, 8'hD0);
        wr_cmd(2'd3, 8'h02, 1);
        @(negedge clk_24);
        rd("clr ovf again", 2'd0, 8'h90);

        // Flush on the same cycle as a key event, then a normal event.
        key_and_cmd(10'h270, 8'h04);
        rd("flush+push status", 2'd0, 8'h00);
        check("flush+push irq", {7'b0, irq_pending}, 8'h00);
        key_ev(10'h271);
        rd("after flush status", 2'd0, 8'h81);
        rd("after flush head", 2'd1, 8'h71);

        // Pop on an empty FIFO while a push arrives: the push is kept.
        wr_cmd(2'd3, 8'h04, 1);
        key_and_cmd(10'h272, 8'h01);
        rd("empty push+pop status", 2'd0, 8'h81);
        rd("empty push+pop head", 2'd1, 8'h72);

        // Reset during a held flush strobe. The strobe must stay inert.
        @(negedge clk_24);
        cpu_cs   = 1'b1;
        cpu_addr = 2'd3;
        cpu_din  = 8'h04;
        cpu_wr_n = 1'b0;
        reset    = 1'b1;
        @(negedge clk_24);
        rd("in reset status", 2'd0, 8'h00);
        check("in reset irq", {7'b0, irq_pending}, 8'h00);
        @(negedge clk_24);
        reset    = 1'b0;
        ps2_key  = {~ps2_key[10], 10'h273};
        cpu_addr = 2'd3;
        @(negedge clk_24);
        rd("held wr after reset", 2'd0, 8'h81);
        cpu_wr_n = 1'b1;
        cpu_cs   = 1'b0;
        wr_cmd(2'd3, 8'h04, 1);
        @(negedge clk_24);
        rd("rearmed flush", 2'd0, 8'h00);

        // Typematic sequence: press x3, release, press.
        for (int i = 0; i < 3; i++) key_ev(10'h229);
        key_ev(10'h029);
        key_ev(10'h229);
`ifdef KEYFIFO_REPEAT_FILTER_EN
        rd("repeat count", 2'd0, 8'h83);
`else
        rd("repeat count", 2'd0, 8'h85);
`endif
        rd("repeat head flags", 2'd2, 8'h02);
        wr_cmd(2'd3, 8'h01, 1);
        @(negedge clk_24);
`ifdef KEYFIFO_REPEAT_FILTER_EN
        rd("repeat second flags", 2'd2, 8'h00);
`else
        rd("repeat second flags", 2'd2, 8'h02);
`endif
        rd("repeat second code", 2'd1, 8'h29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
